idu_exu_queue: RTL and testbench
================================

IDU_EXU_QUEUE -- requirements
Module: idu_exu_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries; power of two, at least 2.
REQ-002 SHALL have parameter XLEN, default 32, meaning width of pc/inst/op1/op2/opj/imm.
REQ-003 SHALL have parameter RD_W, default 4, meaning destination-register index width.
REQ-004 SHALL have these ports (name  direction  width  meaning):
- clk  in  1  sole clock; one clock; reset is asynchronous and active-low.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  IDU offers a decoded bundle.
- in_ready  out  1  queue accepts a bundle.
- in_bits  in  $bits(idu_pipe_t)  decoded bundle.
- out_valid  out  1  head bundle available to EXU.
- out_ready  in  1  EXU consumes the head.
- out_bits  out  $bits(idu_pipe_t)  head bundle.
- flush  in  1  kill all entries (trap/redirect).
- spec_kill  in  1  mispredict: kill speculative entries.
- spec_clear  in  1  branch resolved correct: clear speculation bits.
- count  out  $clog2(DEPTH)+1  current occupancy.

Function
REQ-005 SHALL be a circular FIFO of DEPTH idu_pipe_t entries with first-word fall-through: out_bits = head entry, out_valid = (count != 0), gated per REQ-011.
REQ-006 SHALL assert in_ready = (count != DEPTH); a push when full is not accepted, even if a pop fires in the same cycle.
REQ-007 SHALL push on in_valid && in_ready and pop on out_valid && out_ready; a simultaneous push and pop leaves count unchanged and advances both pointers.
REQ-008 SHALL wrap pointers modulo DEPTH, using one extra pointer bit to distinguish full from empty.
REQ-009 SHALL give a bundle a latency of exactly one cycle from accepted push to out_valid when the queue was empty; there is no combinational in-to-out bypass.
REQ-010 SHALL apply priority flush > spec_kill > spec_clear > push/pop.
REQ-011 SHALL force out_valid low combinationally while flush is high, and while spec_kill is high with a speculative head entry.
REQ-012 flush: SHALL set count and both pointers to 0 at the next edge; a push in the same cycle is discarded.
REQ-013 spec_kill: SHALL move the tail to the oldest entry whose speculation=1, discarding it and all younger entries. A same-cycle push is discarded. A same-cycle pop of a non-speculative head completes. If no entry is speculative, only the push is discarded.
REQ-014 spec_clear: SHALL clear speculation in every valid entry. A bundle pushed in the same cycle SHALL be stored with speculation=0.
REQ-015 SHALL treat spec_clear as having no effect when spec_kill or flush is asserted in the same cycle.
REQ-016 SHALL rely on the invariant that all speculative entries are younger than all non-speculative ones; a simulation assertion SHALL flag a push of a non-speculative bundle while a speculative entry is resident.
REQ-017 SHALL hold out_bits stable while out_valid && !out_ready, except when a spec_clear clears its speculation bit.
REQ-018 SHALL not alter any entry or pointer when in_valid, out_ready, flush, spec_kill and spec_clear are all 0.

Reset
REQ-019 On rst_n=0, SHALL asynchronously clear the pointers, count=0, out_valid=0 and in_ready=1.
REQ-020 On rst_n=0, SHALL clear all storage to zero so that out_bits=0.
REQ-021 Reset asserted mid-transfer SHALL discard all entries; the first post-reset push behaves as into an empty queue.

Structure
REQ-022 SHALL define idu_pipe_t in a shared package, ysyx_pkg, as a packed struct with the fields pc, inst, speculation, op1, op2, opj, alu_op[3:0], rd, imm, ren, wen, jen, ben, system, func3_z, csr_wen, ebreak, ecall and mret.
REQ-023 SHALL keep XLEN and RD_W defaults as package constants.
REQ-024 SHALL place the oldest-speculative-entry search (DEPTH-wide priority finder from head) in one sub-module, idu_exu_queue_specfind; all other logic is flat.

Verification (DEPTH=4)
REQ-025 Push 4 bundles pc=0x80000000..0x8000000C with out_ready=0 -> in_ready=0 and count=4 after the 4th; a 5th push is rejected; draining yields pcs in order.
REQ-026 Hold in_valid=1 and out_ready=1 for 20 cycles with pc incrementing by 4 -> steady count=1, one pop per cycle, no gaps after the first cycle.
REQ-027 Entries pc=0x100(spec=0), 0x104(spec=0), 0x108(spec=1), 0x10C(spec=1), then spec_kill -> count=2 next cycle, then 0x100 and 0x104 drain, then empty.
REQ-028 Queue holds 3 speculative entries; spec_clear together with a push of pc=0x200, spec=1 -> count=4, all four entries have speculation=0; a later spec_kill removes nothing.
REQ-029 Queue full with flush and in_valid asserted together -> count=0, out_valid=0 the same cycle and next, pushed bundle absent.
REQ-030 rst_n pulsed low asynchronously mid-cycle with count=3 -> outputs reset immediately; after release a single push appears at out_bits one cycle later.

Source files
------------

// File: rtl/ysyx_pkg.sv
// Shared IDU/EXU types: decoded bundle layout and default datapath widths.
package ysyx_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned RD_W     = 4;
    localparam int unsigned ALU_OP_W = 4;

    // Decoded instruction bundle handed from IDU to EXU
    typedef struct packed {
        logic [XLEN-1:0]     pc;
        logic [XLEN-1:0]     inst;
        logic                speculation;
        logic [XLEN-1:0]     op1;
        logic [XLEN-1:0]     op2;
        logic [XLEN-1:0]     opj;
        logic [ALU_OP_W-1:0] alu_op;
        logic [RD_W-1:0]     rd;
        logic [XLEN-1:0]     imm;
        logic                ren;
        logic                wen;
        logic                jen;
        logic                ben;
        logic                system;
        logic                func3_z;
        logic                csr_wen;
        logic                ebreak;
        logic                ecall;
        logic                mret;
    } idu_pipe_t;

    // Copy of a bundle with its speculation bit cleared
    function automatic idu_pipe_t clear_spec(input idu_pipe_t b);
        idu_pipe_t r;
        r             = b;
        r.speculation = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/idu_exu_queue_specfind.sv
// Finds the oldest speculative slot, searching forward from the queue head.
module idu_exu_queue_specfind #(
    parameter int unsigned DEPTH = 4
) (
    input  logic [DEPTH-1:0]         spec_i,
    input  logic [$clog2(DEPTH)-1:0] head_i,
    output logic                     found_o,
    output logic [$clog2(DEPTH)-1:0] offset_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [IDX_W-1:0] slot;

    // Scan youngest-to-oldest so the smallest distance from head wins
    always_comb begin
        found_o  = 1'b0;
        offset_o = '0;
        slot     = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            slot = head_i + IDX_W'(k);
            if (spec_i[slot]) begin
                found_o  = 1'b1;
                offset_o = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/idu_exu_queue.sv
// IDU->EXU decoupling FIFO with first-word fall-through and speculation control.
module idu_exu_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = ysyx_pkg::XLEN,
    parameter int unsigned RD_W  = ysyx_pkg::RD_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  ysyx_pkg::idu_pipe_t   in_bits,
    output logic                  out_valid,
    input  logic                  out_ready,
    output ysyx_pkg::idu_pipe_t   out_bits,
    input  logic                  flush,
    input  logic                  spec_kill,
    input  logic                  spec_clear,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    ysyx_pkg::idu_pipe_t mem_q [DEPTH];
    ysyx_pkg::idu_pipe_t mem_d [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic [PTR_W-1:0] occ;

    logic [DEPTH-1:0] live;
    logic [DEPTH-1:0] spec_vec;
    logic [IDX_W-1:0] rel;

    logic             kill_found;
    logic [IDX_W-1:0] kill_offset;

    logic             push;
    logic             pop;

    assign wr_idx = wr_ptr_q[IDX_W-1:0];
    assign rd_idx = rd_ptr_q[IDX_W-1:0];
    assign occ    = wr_ptr_q - rd_ptr_q;

    // Mark which physical slots hold resident entries and which are speculative
    always_comb begin
        live     = '0;
        spec_vec = '0;
        rel      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rel         = IDX_W'(i) - rd_idx;
            live[i]     = ({1'b0, rel} < occ);
            spec_vec[i] = live[i] && mem_q[i].speculation;
        end
    end

    idu_exu_queue_specfind #(
        .DEPTH (DEPTH)
    ) u_specfind (
        .spec_i   (spec_vec),
        .head_i   (rd_idx),
        .found_o  (kill_found),
        .offset_o (kill_offset)
    );

    // Handshake outputs; a killed or flushed head is never offered
    always_comb begin
        count     = occ;
        in_ready  = (occ != PTR_W'(DEPTH));
        out_bits  = mem_q[rd_idx];
        out_valid = (occ != '0) && !flush && !(spec_kill && mem_q[rd_idx].speculation);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    // Next pointers and storage: flush > spec_kill > spec_clear > push/pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else if (spec_kill) begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (kill_found) begin
                wr_ptr_d = rd_ptr_q + PTR_W'(kill_offset);
            end
        end else begin
            if (spec_clear) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (live[i]) begin
                        mem_d[i] = ysyx_pkg::clear_spec(mem_q[i]);
                    end
                end
            end
            if (push) begin
                mem_d[wr_idx] = spec_clear ? ysyx_pkg::clear_spec(in_bits) : in_bits;
                wr_ptr_d      = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // State registers; reset empties the queue and zeroes storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Simulation checks: configuration sanity and speculative-ordering invariant
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (DEPTH >= 2 && (DEPTH & (DEPTH - 1)) == 0)
                else $error("idu_exu_queue: DEPTH must be a power of two >= 2");
            assert (XLEN == $bits(in_bits.pc) && RD_W == $bits(in_bits.rd))
                else $error("idu_exu_queue: XLEN/RD_W disagree with ysyx_pkg");
            if (push && !flush && !spec_kill && !spec_clear) begin
                assert (in_bits.speculation || (spec_vec == '0))
                    else $error("idu_exu_queue: non-speculative push behind speculative entry");
            end
        end
    end

endmodule

// File: tb/tb_idu_exu_queue.sv
// Self-checking bench for idu_exu_queue: directed table, corner sequences, random vs queue model.
module tb_idu_exu_queue;
    import ysyx_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready, out_valid, out_ready;
    logic             flush, spec_kill, spec_clear;
    idu_pipe_t        in_bits, out_bits;
    logic [CNT_W-1:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    idu_pipe_t model_q[$];

    idu_exu_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .RD_W(RD_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_bits    (in_bits),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_bits   (out_bits),
        .flush      (flush),
        .spec_kill  (spec_kill),
        .spec_clear (spec_clear),
        .count      (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          iv, ordy, fl, sk, sc, sp;
        logic [31:0] pc;
        bit          e_ir, e_ov;
        int unsigned e_cnt;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mkv(bit iv, bit ordy, bit sk, bit sp, logic [31:0] pc,
                                 bit e_ir, bit e_ov, int unsigned e_cnt, logic [31:0] e_pc);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.fl = 1'b0; v.sk = sk; v.sc = 1'b0; v.sp = sp; v.pc = pc;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_cnt = e_cnt; v.e_pc = e_pc;
        return v;
    endfunction

    function automatic idu_pipe_t mk(logic [31:0] pc, bit spec);
        idu_pipe_t b;
        b.pc = pc; b.inst = $urandom; b.speculation = spec;
        b.op1 = $urandom; b.op2 = $urandom; b.opj = $urandom;
        b.alu_op = 4'($urandom); b.rd = RD_W'($urandom); b.imm = $urandom;
        {b.ren, b.wen, b.jen, b.ben, b.system, b.func3_z, b.csr_wen, b.ebreak, b.ecall, b.mret} = 10'($urandom);
        return b;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_bundle(string name, idu_pipe_t act, idu_pipe_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got pc=%h spec=%b inst=%h expected pc=%h spec=%b inst=%h (t=%0t)",
                     name, act.pc, act.speculation, act.inst, exp.pc, exp.speculation, exp.inst, $time);
        end
    endtask

    task automatic drive(bit iv, bit ordy, bit fl, bit sk, bit sc, idu_pipe_t b);
        in_valid = iv; out_ready = ordy; flush = fl; spec_kill = sk; spec_clear = sc; in_bits = b;
    endtask

    function automatic bit model_out_valid();
        if (model_q.size() == 0) return 1'b0;
        if (flush) return 1'b0;
        if (spec_kill && model_q[0].speculation) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit model_has_spec();
        foreach (model_q[i]) if (model_q[i].speculation) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_check();
        int unsigned sz = model_q.size();
        chk("count", 64'(count), 64'(sz));
        chk("in_ready", 64'(in_ready), 64'(sz < DEPTH));
        chk("out_valid", 64'(out_valid), 64'(model_out_valid()));
        if (sz != 0) chk_bundle("out_bits", out_bits, model_q[0]);
    endtask

    // Advance the reference queue by one clock using the currently driven inputs
    task automatic model_update();
        bit        do_pop  = model_out_valid() && out_ready;
        bit        do_push = in_valid && (model_q.size() < DEPTH);
        idu_pipe_t b;
        if (flush) begin
            model_q.delete();
        end else if (spec_kill) begin
            int cut = -1;
            if (do_pop) void'(model_q.pop_front());
            for (int i = 0; i < model_q.size(); i++)
                if (cut < 0 && model_q[i].speculation) cut = i;
            if (cut >= 0)
                while (model_q.size() > cut) void'(model_q.pop_back());
        end else begin
            if (spec_clear)
                for (int i = 0; i < model_q.size(); i++) begin
                    b = model_q[i]; b.speculation = 1'b0; model_q[i] = b;
                end
            if (do_pop) void'(model_q.pop_front());
            if (do_push) begin
                b = in_bits;
                if (spec_clear) b.speculation = 1'b0;
                model_q.push_back(b);
            end
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(logic [31:0] pc, bit spec);
        drive(1, 0, 0, 0, 0, mk(pc, spec));
        @(negedge clk);
        tick();
    endtask

    initial begin
        idu_pipe_t   zero_b = '0;
        logic [31:0] exp_pcs [4];
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, zero_b);

        // Reset state
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk_bundle("rst_out_bits", out_bits, zero_b);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table: fill/overflow/drain, then kill of speculative tail
        tbl[0]  = mkv(1, 0, 0, 0, 32'h8000_0000, 1, 0, 0, 32'h0);
        tbl[1]  = mkv(1, 0, 0, 0, 32'h8000_0004, 1, 1, 1, 32'h8000_0000);
        tbl[2]  = mkv(1, 0, 0, 0, 32'h8000_0008, 1, 1, 2, 32'h8000_0000);
        tbl[3]  = mkv(1, 0, 0, 0, 32'h8000_000C, 1, 1, 3, 32'h8000_0000);
        tbl[4]  = mkv(1, 0, 0, 0, 32'h8000_0010, 0, 1, 4, 32'h8000_0000);
        tbl[5]  = mkv(0, 1, 0, 0, 32'h0,         0, 1, 4, 32'h8000_0000);
        tbl[6]  = mkv(0, 1, 0, 0, 32'h0,         1, 1, 3, 32'h8000_0004);
        tbl[7]  = mkv(0, 1, 0, 0, 32'h0,         1, 1, 2, 32'h8000_0008);
        tbl[8]  = mkv(0, 1, 0, 0, 32'h0,         1, 1, 1, 32'h8000_000C);
        tbl[9]  = mkv(0, 0, 0, 0, 32'h0,         1, 0, 0, 32'h0);
        tbl[10] = mkv(1, 0, 0, 0, 32'h100,       1, 0, 0, 32'h0);
        tbl[11] = mkv(1, 0, 0, 0, 32'h104,       1, 1, 1, 32'h100);
        tbl[12] = mkv(1, 0, 0, 1, 32'h108,       1, 1, 2, 32'h100);
        tbl[13] = mkv(1, 0, 0, 1, 32'h10C,       1, 1, 3, 32'h100);
        tbl[14] = mkv(0, 0, 1, 0, 32'h0,         0, 1, 4, 32'h100);
        tbl[15] = mkv(0, 1, 0, 0, 32'h0,         1, 1, 2, 32'h100);
        tbl[16] = mkv(0, 1, 0, 0, 32'h0,         1, 1, 1, 32'h104);
        tbl[17] = mkv(0, 0, 0, 0, 32'h0,         1, 0, 0, 32'h0);
        for (int r = 0; r < 18; r++) begin
            drive(tbl[r].iv, tbl[r].ordy, tbl[r].fl, tbl[r].sk, tbl[r].sc, mk(tbl[r].pc, tbl[r].sp));
            @(negedge clk);
            chk($sformatf("tbl%0d_count", r), 64'(count), 64'(tbl[r].e_cnt));
            chk($sformatf("tbl%0d_in_ready", r), 64'(in_ready), 64'(tbl[r].e_ir));
            chk($sformatf("tbl%0d_out_valid", r), 64'(out_valid), 64'(tbl[r].e_ov));
            if (tbl[r].e_ov) chk($sformatf("tbl%0d_pc", r), 64'(out_bits.pc), 64'(tbl[r].e_pc));
            tick();
        end

        // Streaming: push and pop every cycle holds occupancy at one
        for (int k = 0; k < 20; k++) begin
            drive(1, 1, 0, 0, 0, mk(32'h1000 + 32'(4 * k), 0));
            @(negedge clk);
            if (k == 0) begin
                chk("stream_count0", 64'(count), 64'd0);
                chk("stream_valid0", 64'(out_valid), 64'd0);
            end else begin
                chk("stream_count", 64'(count), 64'd1);
                chk("stream_valid", 64'(out_valid), 64'd1);
                chk("stream_pc", 64'(out_bits.pc), 64'(32'h1000 + 32'(4 * (k - 1))));
            end
            tick();
        end
        drive(0, 1, 0, 0, 0, zero_b);
        @(negedge clk);
        chk("stream_last_pc", 64'(out_bits.pc), 64'(32'h1000 + 32'd76));
        tick();
        drive(0, 0, 0, 0, 0, zero_b);
        @(negedge clk);
        chk("stream_empty", 64'(count), 64'd0);
        tick();

        // spec_clear with a speculative push: everything becomes committed
        push_one(32'h300, 1);
        push_one(32'h304, 1);
        push_one(32'h308, 1);
        drive(1, 0, 0, 0, 1, mk(32'h200, 1));
        @(negedge clk);
        chk("clr_count_before", 64'(count), 64'd3);
        tick();
        drive(0, 0, 0, 1, 0, zero_b);
        @(negedge clk);
        chk("clr_count", 64'(count), 64'd4);
        chk("clr_kill_out_valid", 64'(out_valid), 64'd1);
        tick();
        exp_pcs[0] = 32'h300; exp_pcs[1] = 32'h304; exp_pcs[2] = 32'h308; exp_pcs[3] = 32'h200;
        for (int j = 0; j < 4; j++) begin
            drive(0, 1, 0, 0, 0, zero_b);
            @(negedge clk);
            chk("clr_drain_count", 64'(count), 64'(4 - j));
            chk("clr_drain_pc", 64'(out_bits.pc), 64'(exp_pcs[j]));
            chk("clr_drain_spec", 64'(out_bits.speculation), 64'd0);
            tick();
        end

        // Flush on a full queue discards everything including the same-cycle push
        for (int j = 0; j < 4; j++) push_one(32'h400 + 32'(4 * j), 0);
        drive(1, 1, 1, 0, 0, mk(32'h500, 0));
        @(negedge clk);
        chk("flush_out_valid_same", 64'(out_valid), 64'd0);
        chk("flush_count_same", 64'(count), 64'd4);
        tick();
        drive(0, 1, 0, 0, 0, zero_b);
        @(negedge clk);
        chk("flush_count_next", 64'(count), 64'd0);
        chk("flush_out_valid_next", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        tick();

        // Asynchronous reset mid-cycle with three resident entries
        for (int j = 0; j < 3; j++) push_one(32'h600 + 32'(4 * j), 0);
        drive(0, 0, 0, 0, 0, zero_b);
        #3;
        rst_n = 1'b0;
        #1;
        model_q.delete();
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk_bundle("arst_out_bits", out_bits, zero_b);
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        drive(1, 0, 0, 0, 0, mk(32'h700, 0));
        @(negedge clk);
        chk("post_rst_count0", 64'(count), 64'd0);
        tick();
        drive(0, 1, 0, 0, 0, zero_b);
        @(negedge clk);
        chk("post_rst_count1", 64'(count), 64'd1);
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_pc", 64'(out_bits.pc), 64'h700);
        tick();

        // Random traffic against the queue model
        for (int c = 0; c < 600; c++) begin
            bit spec;
            spec = model_has_spec() ? 1'b1 : ($urandom_range(0, 2) == 0);
            drive($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 24) == 0, $urandom_range(0, 11) == 0,
                  $urandom_range(0, 9) == 0, mk($urandom, spec));
            @(negedge clk);
            model_check();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
